// File: rtl/countdown_timer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// countdown_timer_ctrl_pkg
//   Shared definitions for the countdown timer controller and its prescaler.
//   - state_t      : 2-bit FSM encoding, also driven out on the state port
//   - DIV_DEFAULT  : prescaler period for a 1 s tick from a 100 MHz clk
//   - DIV_SIM      : short prescaler period used by simulation benches
// -----------------------------------------------------------------------------
package countdown_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DIV_DEFAULT = 100_000_000;
  localparam int DIV_SIM     = 4;
  localparam int CW_DEFAULT  = 32;
  localparam int W_DEFAULT   = 8;

  // Busy covers both the counting and the frozen (paused) phases.
  function automatic logic state_is_busy(input state_t s);
    return (s == ST_RUN) || (s == ST_PAUSE);
  endfunction

endpackage

// File: rtl/countdown_timer_ctrl_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
//   Divides clk into a one-cycle tick enable; no derived clock is produced, so
//   consumers stay on clk. Reusable by any block that needs a slow strobe.
//
//   Ports
//     clk        in   system clock
//     rst        in   synchronous active-high reset
//     en         in   count enable; counter holds its value while low
//     sclr       in   synchronous clear of counter and tick (below rst only)
//     tick       out  registered pulse, high the cycle after a period end
//     period_end out  combinational strobe: the current cycle ends a period
//                     (en high and counter at DIV-1); lets a parent update its
//                     own registers on the same edge that raises tick
// -----------------------------------------------------------------------------
module tick_prescaler #(
  parameter int DIV = 4,
  parameter int CW  = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sclr,
  output logic tick,
  output logic period_end
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign period_end = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (sclr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (en) begin
        if (cnt == LAST) begin
          cnt  <= '0;
          tick <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// -----------------------------------------------------------------------------
// countdown_timer_ctrl
//   Loadable countdown timer: a prescaler produces one tick per DIV cycles
//   while running, and each tick decrements the remaining count. Expiry gives
//   a one-cycle done pulse and a level alarm held until clear or start.
//
//   Ports
//     clk        in   system clock (sole domain)
//     rst        in   synchronous active-high reset, highest priority
//     start      in   pulse: load load_val and run (accepted in IDLE/DONE only)
//     pause      in   pulse: toggle RUN <-> PAUSE
//     clear      in   pulse: abort to IDLE with remaining cleared
//     load_val   in   start value in ticks, sampled on an accepted start
//     tick       out  one-cycle pulse per completed prescaler period in RUN
//     remaining  out  current count
//     busy       out  high in RUN or PAUSE
//     done       out  one-cycle pulse on expiry
//     alarm      out  high while in DONE
//     state      out  FSM state encoding
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | stopped, remaining = 0, waiting for start
//   ST_RUN   | prescaler counting, remaining decrements each period end
//   ST_PAUSE | prescaler and remaining frozen, pause resumes
//   ST_DONE  | expired, alarm high, waiting for clear or start
//
//   Input priority within a cycle: clear > start > pause > period end.
// -----------------------------------------------------------------------------
module countdown_timer_ctrl #(
  parameter int DIV = countdown_timer_ctrl_pkg::DIV_DEFAULT,
  parameter int CW  = countdown_timer_ctrl_pkg::CW_DEFAULT,
  parameter int W   = countdown_timer_ctrl_pkg::W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         pause,
  input  logic         clear,
  input  logic [W-1:0] load_val,
  output logic         tick,
  output logic [W-1:0] remaining,
  output logic         busy,
  output logic         done,
  output logic         alarm,
  output logic [1:0]   state
);

  import countdown_timer_ctrl_pkg::*;

  state_t       state_q, state_d;
  logic [W-1:0] rem_q, rem_d;
  logic         done_q, done_d;
  logic         pre_en, pre_sclr, period_end;

  // Counting happens only in RUN; the prescaler holds its count otherwise.
  assign pre_en = (state_q == ST_RUN);

  tick_prescaler #(
    .DIV (DIV),
    .CW  (CW)
  ) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .en         (pre_en),
    .sclr       (pre_sclr),
    .tick       (tick),
    .period_end (period_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    done_d   = 1'b0;
    pre_sclr = 1'b0;

    if (clear) begin
      // Clearing the prescaler also kills a tick that would land this cycle.
      state_d  = ST_IDLE;
      rem_d    = '0;
      pre_sclr = 1'b1;
    end else if (start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
      pre_sclr = 1'b1;
      if (load_val != '0) begin
        state_d = ST_RUN;
        rem_d   = load_val;
      end else begin
        state_d = ST_DONE;
        rem_d   = '0;
        done_d  = 1'b1;
      end
    end else begin
      // A start in RUN/PAUSE is ignored and does not mask pause.
      unique case (state_q)
        ST_RUN: begin
          if (period_end) begin
            // Expiry takes precedence over a coincident pause. The prescaler
            // wraps to 0 on its own here, so no clear is needed and the final
            // tick still coincides with done.
            if (rem_q <= W'(1)) begin
              state_d = ST_DONE;
              rem_d   = '0;
              done_d  = 1'b1;
            end else begin
              rem_d = rem_q - W'(1);
              if (pause) state_d = ST_PAUSE;
            end
          end else if (pause) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (pause) state_d = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  assign remaining = rem_q;
  assign done      = done_q;
  assign alarm     = (state_q == ST_DONE);
  assign busy      = state_is_busy(state_q);
  assign state     = state_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
module tb_countdown_timer_ctrl;

  import countdown_timer_ctrl_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         tick;
  logic [W-1:0] remaining;
  logic         busy;
  logic         done;
  logic         alarm;
  logic [1:0]   state;

  countdown_timer_ctrl #(
    .DIV (DIV_SIM),
    .CW  (32),
    .W   (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .clear     (clear),
    .load_val  (load_val),
    .tick      (tick),
    .remaining (remaining),
    .busy      (busy),
    .done      (done),
    .alarm     (alarm),
    .state     (state)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; "edge n" effects are visible at cyc==n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int tick_cnt = 0;
  int done_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Packed view {tick, done, alarm, busy, remaining, state}.
  function automatic logic [13:0] ev(input logic t, input logic d, input logic a,
                                     input logic b, input logic [7:0] r, input state_t s);
    return {t, d, a, b, r, s};
  endfunction

  typedef struct {
    int          at;
    string       tag;
    logic [13:0] v;
  } exp_t;

  exp_t sb[$];

  task automatic expect_at(input int at, input string tag, input logic [13:0] v);
    exp_t e;
    e.at = at; e.tag = tag; e.v = v;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (tick) tick_cnt++;
    if (done) done_cnt++;
    while (sb.size() > 0 && sb[0].at == cyc) begin
      exp_t e;
      e = sb.pop_front();
      check_val(e.tag, {18'd0, tick, done, alarm, busy, remaining, state}, {18'd0, e.v});
    end
  end

  task automatic wait_cyc(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // Called at a negedge; inputs are sampled at the next rising edge.
  task automatic drive(input logic r, input logic s, input logic p, input logic c,
                       input logic [W-1:0] lv);
    rst = r; start = s; pause = p; clear = c; load_val = lv;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0; load_val = '0;
  endtask

  int t0, t1, tb0, db0;

  initial begin
    repeat (2) @(negedge clk);
    check_val("reset_outputs", {18'd0, tick, done, alarm, busy, remaining, state},
              {18'd0, ev(0, 0, 0, 0, 8'd0, ST_IDLE)});
    rst = 1'b0;
    @(negedge clk);

    // 1: load 3, ticks at +4/+8/+12, done at +12
    t0 = cyc + 1; tb0 = tick_cnt; db0 = done_cnt;
    expect_at(t0,      "t1_start", ev(0, 0, 0, 1, 8'd3, ST_RUN));
    expect_at(t0 + 3,  "t1_pre",   ev(0, 0, 0, 1, 8'd3, ST_RUN));
    expect_at(t0 + 4,  "t1_tk1",   ev(1, 0, 0, 1, 8'd2, ST_RUN));
    expect_at(t0 + 5,  "t1_tk1+1", ev(0, 0, 0, 1, 8'd2, ST_RUN));
    expect_at(t0 + 8,  "t1_tk2",   ev(1, 0, 0, 1, 8'd1, ST_RUN));
    expect_at(t0 + 11, "t1_pre3",  ev(0, 0, 0, 1, 8'd1, ST_RUN));
    expect_at(t0 + 12, "t1_exp",   ev(1, 1, 1, 0, 8'd0, ST_DONE));
    expect_at(t0 + 13, "t1_hold",  ev(0, 0, 1, 0, 8'd0, ST_DONE));
    drive(0, 1, 0, 0, 8'd3);
    wait_cyc(t0 + 16); #1;
    check_val("t1_ticks", tick_cnt - tb0, 3);
    check_val("t1_dones", done_cnt - db0, 1);

    // 2: load 5, pause sampled at +6, resume at +20, done at +34
    t0 = cyc + 1; tb0 = tick_cnt;
    expect_at(t0 + 4,  "t2_tk1",    ev(1, 0, 0, 1, 8'd4, ST_RUN));
    expect_at(t0 + 6,  "t2_paused", ev(0, 0, 0, 1, 8'd4, ST_PAUSE));
    expect_at(t0 + 13, "t2_frozen", ev(0, 0, 0, 1, 8'd4, ST_PAUSE));
    expect_at(t0 + 20, "t2_resume", ev(0, 0, 0, 1, 8'd4, ST_RUN));
    expect_at(t0 + 21, "t2_pre",    ev(0, 0, 0, 1, 8'd4, ST_RUN));
    expect_at(t0 + 22, "t2_tk2",    ev(1, 0, 0, 1, 8'd3, ST_RUN));
    expect_at(t0 + 26, "t2_tk3",    ev(1, 0, 0, 1, 8'd2, ST_RUN));
    expect_at(t0 + 30, "t2_tk4",    ev(1, 0, 0, 1, 8'd1, ST_RUN));
    expect_at(t0 + 34, "t2_exp",    ev(1, 1, 1, 0, 8'd0, ST_DONE));
    drive(0, 1, 0, 0, 8'd5);
    wait_cyc(t0 + 5);  drive(0, 0, 1, 0, 8'd0);
    wait_cyc(t0 + 19); drive(0, 0, 1, 0, 8'd0);
    wait_cyc(t0 + 36); #1;
    check_val("t2_ticks", tick_cnt - tb0, 5);

    // 3: clear, then start with load 0 goes straight to DONE
    t0 = cyc + 1;
    expect_at(t0, "t3_clear", ev(0, 0, 0, 0, 8'd0, ST_IDLE));
    drive(0, 0, 0, 1, 8'd0);
    t0 = cyc + 1; tb0 = tick_cnt;
    expect_at(t0,     "t3_zero",  ev(0, 1, 1, 0, 8'd0, ST_DONE));
    expect_at(t0 + 1, "t3_hold",  ev(0, 0, 1, 0, 8'd0, ST_DONE));
    expect_at(t0 + 6, "t3_later", ev(0, 0, 1, 0, 8'd0, ST_DONE));
    drive(0, 1, 0, 0, 8'd0);
    wait_cyc(t0 + 8); #1;
    check_val("t3_ticks", tick_cnt - tb0, 0);

    // 4: clear+start on a period end with remaining=2, then reload 2
    t0 = cyc + 1;
    expect_at(t0 + 4, "t4_tk1",   ev(1, 0, 0, 1, 8'd2, ST_RUN));
    expect_at(t0 + 8, "t4_clr",   ev(0, 0, 0, 0, 8'd0, ST_IDLE));
    expect_at(t0 + 9, "t4_clr+1", ev(0, 0, 0, 0, 8'd0, ST_IDLE));
    drive(0, 1, 0, 0, 8'd3);
    wait_cyc(t0 + 7); drive(0, 1, 0, 1, 8'd7);
    wait_cyc(t0 + 10);
    t1 = cyc + 1;
    expect_at(t1,     "t4_reload", ev(0, 0, 0, 1, 8'd2, ST_RUN));
    expect_at(t1 + 4, "t4_rtk1",   ev(1, 0, 0, 1, 8'd1, ST_RUN));
    expect_at(t1 + 7, "t4_pre",    ev(0, 0, 0, 1, 8'd1, ST_RUN));
    expect_at(t1 + 8, "t4_exp",    ev(1, 1, 1, 0, 8'd0, ST_DONE));
    drive(0, 1, 0, 0, 8'd2);
    wait_cyc(t1 + 10);

    // 5: rst on a period end mid-RUN, then a normal load-1 run
    t0 = cyc + 1;
    expect_at(t0,     "t5_start", ev(0, 0, 0, 1, 8'd5, ST_RUN));
    expect_at(t0 + 4, "t5_rst",   ev(0, 0, 0, 0, 8'd0, ST_IDLE));
    expect_at(t0 + 5, "t5_rst+1", ev(0, 0, 0, 0, 8'd0, ST_IDLE));
    drive(0, 1, 0, 0, 8'd5);
    wait_cyc(t0 + 3); drive(1, 0, 0, 0, 8'd0);
    wait_cyc(t0 + 6);
    t1 = cyc + 1;
    expect_at(t1,     "t5_run",  ev(0, 0, 0, 1, 8'd1, ST_RUN));
    expect_at(t1 + 3, "t5_pre",  ev(0, 0, 0, 1, 8'd1, ST_RUN));
    expect_at(t1 + 4, "t5_exp",  ev(1, 1, 1, 0, 8'd0, ST_DONE));
    drive(0, 1, 0, 0, 8'd1);
    wait_cyc(t1 + 6);

    // 6: start ignored in RUN; pause on the final period end; pause in DONE
    t0 = cyc + 1;
    expect_at(t0,      "t6_start",   ev(0, 0, 0, 1, 8'd2, ST_RUN));
    expect_at(t0 + 2,  "t6_noreld",  ev(0, 0, 0, 1, 8'd2, ST_RUN));
    expect_at(t0 + 4,  "t6_tk1",     ev(1, 0, 0, 1, 8'd1, ST_RUN));
    expect_at(t0 + 8,  "t6_exp",     ev(1, 1, 1, 0, 8'd0, ST_DONE));
    expect_at(t0 + 10, "t6_pdone",   ev(0, 0, 1, 0, 8'd0, ST_DONE));
    expect_at(t0 + 12, "t6_hold",    ev(0, 0, 1, 0, 8'd0, ST_DONE));
    drive(0, 1, 0, 0, 8'd2);
    wait_cyc(t0 + 1); drive(0, 1, 0, 0, 8'd9);
    wait_cyc(t0 + 7); drive(0, 0, 1, 0, 8'd0);
    wait_cyc(t0 + 9); drive(0, 0, 1, 0, 8'd0);
    wait_cyc(t0 + 14);

    check_val("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer_ctrl.md
Name: countdown_timer_ctrl

Overview:
Sequences a prescaler to run a loadable countdown timer for the board-level game/alarm logic.
- Produces a single-cycle tick enable, not a derived clock, so all downstream logic stays on clk.
- Owns the run/pause/stop state machine and the remaining-count register.
- Flags expiry with a one-cycle done pulse and a level alarm.

Parameters:
DIV, 100_000_000, clk cycles per tick (1 s at 100 MHz); benches override to 4.
CW, 32, prescaler counter width; must hold DIV-1.
W, 8, width of load value and remaining count.

Ports:
clk  input  1  system clock; sole clock domain.
rst  input  1  synchronous, active-high reset.
start  input  1  pulse; load load_val and begin counting.
pause  input  1  pulse; toggles RUN<->PAUSE.
clear  input  1  pulse; abort to IDLE, remaining cleared.
load_val  input  W  start value in ticks; sampled only on an accepted start.
tick  output  1  one-cycle pulse each completed prescaler period while in RUN.
remaining  output  W  current count.
busy  output  1  high in RUN or PAUSE.
done  output  1  one-cycle pulse on expiry.
alarm  output  1  level, high in DONE.
state  output  2  current FSM state encoding.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE, prescaler cnt=0, remaining=0.
  - tick=0, done=0, alarm=0, busy=0.
  - rst has priority over every other input.
- States (2-bit):
  - IDLE=0, RUN=1, PAUSE=2, DONE=3.
- Input priority per cycle: clear > start > pause > tick event.
- Prescaler:
  - cnt counts 0..DIV-1 only in RUN.
  - At cnt==DIV-1: cnt wraps to 0 and tick=1 in the following cycle (registered).
  - Held in PAUSE.
  - Forced to 0 on reset, clear, accepted start, and entry to DONE.
- IDLE/DONE + start:
  - load_val!=0: remaining<=load_val, cnt<=0, state<=RUN. busy high the next cycle.
  - load_val==0: state<=DONE, done=1 the next cycle, remaining=0.
- RUN:
  - Each period end decrements remaining by 1.
  - If remaining==1 at period end: remaining<=0, state<=DONE, done=1 for exactly one cycle (coincident with the final tick).
  - First tick occurs DIV cycles after start is sampled.
- start while RUN or PAUSE: ignored; no reload.
- pause:
  - RUN->PAUSE and PAUSE->RUN.
  - Ignored in IDLE/DONE.
  - If pause coincides with a period end in RUN: the decrement and tick are applied, then the FSM enters PAUSE. If that period end also expires the count, DONE wins and pause is dropped.
- clear:
  - From any state: state<=IDLE, remaining<=0, cnt<=0.
  - Suppresses any same-cycle tick or done.
- DONE:
  - alarm=1, busy=0, remaining=0.
  - Held until clear or start.
- Arithmetic:
  - remaining never decrements below 0; no wrap-around.
  - cnt compare uses full CW bits.
  - DIV=1 gives a tick every RUN cycle.
- Outputs are all registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - state encodings (ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE);
  - default DIV for 100 MHz;
  - simulation DIV=4.
- One natural sub-module, tick_prescaler (clk, rst, en, sclr -> tick). It is reusable by other blocks that currently toggle slow clocks.
- The FSM and remaining register live in the top.

Test Plan:
1. DIV=4, load_val=3, start at cycle 0 -> ticks at cycles 4, 8, 12; remaining goes 3->2->1->0; done pulse at cycle 12 only; alarm high from cycle 12; busy low from cycle 12.
2. DIV=4, load_val=5, start, pause at cycle 6, pause again at cycle 20 -> remaining stays 4 and cnt frozen across cycles 7..20; next tick at cycle 22; total run time 20+14 cycles; done at cycle 34.
3. load_val=0, start -> state=DONE, done=1 next cycle, no tick ever, remaining=0.
4. RUN with remaining=2: assert clear and start in the same cycle -> IDLE, remaining=0, no tick or done that cycle; a later start with load_val=2 reloads and expires after 8 cycles.
5. rst asserted mid-RUN on a period-end cycle -> next cycle all outputs at reset values, tick=0, state=IDLE; start after reset runs normally.
6. pause coinciding with the final period end (remaining=1) -> DONE entered, done pulse emitted, state stays DONE; a following pause is ignored.
